// File: rtl/comp2_pkg.sv
// Shared types for the signed shift-add multiplier
// and its sign-correction neighbour.
package comp2_pkg;
  localparam int DW = 8;
  localparam int PW = 2 * DW;

  typedef logic [PW-1:0] product_t;
  typedef logic [DW-1:0] operand_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_e;
endpackage

// File: rtl/abs_value.sv
// Two's-complement operand to sign plus unsigned magnitude.
// The most-negative input maps to 2^(W-1), which still fits in W bits.
module abs_value
  import comp2_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [W-1:0] val_i,
  output logic         sign_o,
  output logic [W-1:0] mag_o
);

  assign sign_o = val_i[W-1];
  assign mag_o  = sign_o ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential magnitude multiplier: one multiplier bit per cycle,
// signs passed through for the downstream sign-correction stage.
module shift_add_multiplier
  import comp2_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [DW-1:0]   i_multiplicand,
  input  logic [DW-1:0]   i_multiplier,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*DW-1:0] o_product,
  output logic            o_signA,
  output logic            o_signB
);

  localparam int PW    = 2 * DW;
  localparam int CNT_W = $clog2(DW + 1);

  mult_state_e state_q, state_d;

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [DW-1:0]    mb_q, mb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             sa_out_q, sa_out_d;
  logic             sb_out_q, sb_out_d;

  logic            sign_a, sign_b;
  logic [DW-1:0]   mag_a, mag_b;

  abs_value #(.W(DW)) u_abs_a (
    .val_i  (i_multiplicand),
    .sign_o (sign_a),
    .mag_o  (mag_a)
  );

  abs_value #(.W(DW)) u_abs_b (
    .val_i  (i_multiplier),
    .sign_o (sign_b),
    .mag_o  (mag_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mb_q     <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      prod_q   <= '0;
      sa_out_q <= 1'b0;
      sb_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mb_q     <= mb_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      prod_q   <= prod_d;
      sa_out_q <= sa_out_d;
      sb_out_q <= sb_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    prod_d   = prod_q;
    sa_out_d = sa_out_q;
    sb_out_d = sb_out_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          sa_d    = sign_a;
          sb_d    = sign_b;
          mcand_d = {{DW{1'b0}}, mag_a};
          mb_d    = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = mb_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d = mcand_q << 1;
        mb_d    = mb_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Results publish only on the final iteration.
        if (cnt_q == CNT_W'(DW - 1)) begin
          state_d  = DONE;
          prod_d   = acc_d;
          sa_out_d = sa_q;
          sb_out_d = sb_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_product = prod_q;
  assign o_signA   = sa_out_q;
  assign o_signB   = sb_out_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks for shift_add_multiplier.
// Expected products come from integer reference arithmetic.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_multiplicand;
  logic [7:0]  i_multiplier;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_product;
  logic        o_signA;
  logic        o_signB;

  int vectors;
  int miscompares;

  shift_add_multiplier #(.DW(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_product      (o_product),
    .o_signA        (o_signA),
    .o_signB        (o_signB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from IDLE; returns latency, result, busy and hold errors.
  task automatic run_op(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output int          lat,
    output logic [15:0] p,
    output logic        sa,
    output logic        sb,
    output int          busy_bad,
    output int          held_bad
  );
    logic [15:0] prev;
    prev = o_product;
    i_multiplicand = a;
    i_multiplier   = b;
    i_start        = 1'b1;
    step();
    i_start        = 1'b0;
    i_multiplicand = 8'h5A;
    i_multiplier   = 8'hC3;
    lat      = 1;
    busy_bad = 0;
    held_bad = 0;
    while (!o_done && lat < 40) begin
      if (!o_busy) busy_bad++;
      if (o_product !== prev) held_bad++;
      step();
      lat++;
    end
    if (!o_busy) busy_bad++;
    p  = o_product;
    sa = o_signA;
    sb = o_signB;
    step();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    i_start        = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %0b want 0", o_busy);
    end
    vectors++;
    if (o_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done got %0b want 0", o_done);
    end
    vectors++;
    if (o_product !== 16'h0 || o_signA !== 1'b0 || o_signB !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got p=%h sa=%0b sb=%0b want 0/0/0",
               o_product, o_signA, o_signB);
    end
  endtask

  task automatic test_basic();
    int lat, bb, hb;
    logic [15:0] p;
    logic sa, sb;
    run_op(8'd5, 8'd3, lat, p, sa, sb, bb, hb);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 9", lat);
    end
    vectors++;
    if (p !== 16'd15 || sa !== 1'b0 || sb !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result got p=%0d sa=%0b sb=%0b want 15/0/0", p, sa, sb);
    end
    vectors++;
    if (bb !== 0 || hb !== 0) begin
      miscompares++;
      $display("FAIL basic_busy_hold got busy_err=%0d hold_err=%0d want 0/0", bb, hb);
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle_after got busy=%0b want 0", o_busy);
    end
  endtask

  task automatic test_signed();
    int lat, bb, hb;
    logic [15:0] p, corr;
    logic sa, sb;
    run_op(8'hF9, 8'd6, lat, p, sa, sb, bb, hb);
    corr = (sa ^ sb) ? (~p + 16'd1) : p;
    vectors++;
    if (p !== 16'd42 || sa !== 1'b1 || sb !== 1'b0) begin
      miscompares++;
      $display("FAIL neg7x6 got p=%0d sa=%0b sb=%0b want 42/1/0", p, sa, sb);
    end
    vectors++;
    if (corr !== 16'hFFD6) begin
      miscompares++;
      $display("FAIL neg7x6_corrected got %h want ffd6", corr);
    end
  endtask

  task automatic test_extremes();
    int lat, bb, hb;
    logic [15:0] p;
    logic sa, sb;
    run_op(8'h80, 8'h80, lat, p, sa, sb, bb, hb);
    vectors++;
    if (p !== 16'h4000 || sa !== 1'b1 || sb !== 1'b1) begin
      miscompares++;
      $display("FAIL min_x_min got p=%h sa=%0b sb=%0b want 4000/1/1", p, sa, sb);
    end
    run_op(8'h80, 8'h7F, lat, p, sa, sb, bb, hb);
    vectors++;
    if (p !== 16'd16256 || sa !== 1'b1 || sb !== 1'b0) begin
      miscompares++;
      $display("FAIL min_x_max got p=%0d sa=%0b sb=%0b want 16256/1/0", p, sa, sb);
    end
  endtask

  task automatic test_zero_one();
    int lat, bb, hb;
    logic [15:0] p;
    logic sa, sb;
    run_op(8'd0, 8'hFB, lat, p, sa, sb, bb, hb);
    vectors++;
    if (p !== 16'd0 || sa !== 1'b0 || sb !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_x_neg5 got p=%0d sa=%0b sb=%0b want 0/0/1", p, sa, sb);
    end
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL zero_latency got %0d want 9", lat);
    end
    run_op(8'd1, 8'd1, lat, p, sa, sb, bb, hb);
    vectors++;
    if (p !== 16'd1 || sa !== 1'b0 || sb !== 1'b0) begin
      miscompares++;
      $display("FAIL one_x_one got p=%0d sa=%0b sb=%0b want 1/0/0", p, sa, sb);
    end
  endtask

  task automatic test_back_to_back();
    int dones, done_cyc;
    logic [15:0] p;
    dones    = 0;
    done_cyc = 0;
    p        = '0;
    i_multiplicand = 8'd3;
    i_multiplier   = 8'd4;
    i_start        = 1'b1;
    step();
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      i_start = (cyc == 3 || cyc == 9);
      if (i_start) begin
        i_multiplicand = 8'd9;
        i_multiplier   = 8'd9;
      end
      if (o_done) begin
        dones++;
        done_cyc = cyc;
        p = o_product;
      end
      step();
    end
    i_start = 1'b0;
    vectors++;
    if (dones !== 1 || done_cyc !== 9) begin
      miscompares++;
      $display("FAIL b2b_done got count=%0d cyc=%0d want 1/9", dones, done_cyc);
    end
    vectors++;
    if (p !== 16'd12 || o_product !== 16'd12) begin
      miscompares++;
      $display("FAIL b2b_product got %0d/%0d want 12/12", p, o_product);
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ignored_start got busy=%0b want 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bb, hb, dones;
    logic [15:0] p;
    logic sa, sb;
    i_multiplicand = 8'd10;
    i_multiplier   = 8'd10;
    i_start        = 1'b1;
    step();
    i_start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_product !== 16'h0 ||
        o_signA !== 1'b0 || o_signB !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs got b=%0b d=%0b p=%h sa=%0b sb=%0b want all 0",
               o_busy, o_done, o_product, o_signA, o_signB);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_done) dones++;
      step();
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_done got %0d want 0", dones);
    end
    run_op(8'd2, 8'd2, lat, p, sa, sb, bb, hb);
    vectors++;
    if (p !== 16'd4 || lat !== 9) begin
      miscompares++;
      $display("FAIL midrst_restart got p=%0d lat=%0d want 4/9", p, lat);
    end
  endtask

  task automatic test_random();
    int lat, bb, hb, ai, bi, ma, mb;
    logic [7:0] a, b;
    logic [15:0] p, exp_p;
    logic sa, sb;
    for (int n = 0; n < 16; n++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      ai = int'($signed(a));
      bi = int'($signed(b));
      ma = (ai < 0) ? -ai : ai;
      mb = (bi < 0) ? -bi : bi;
      exp_p = 16'(ma * mb);
      run_op(a, b, lat, p, sa, sb, bb, hb);
      vectors++;
      if (p !== exp_p || sa !== (ai < 0) || sb !== (bi < 0) || lat !== 9) begin
        miscompares++;
        $display("FAIL rand a=%h b=%h got p=%h sa=%0b sb=%0b lat=%0d want %h/%0b/%0b/9",
                 a, b, p, sa, sb, lat, exp_p, ai < 0, bi < 0);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_signed();
    test_extremes();
    test_zero_one();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
